apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB slave register file; sits directly downstream of the APB master interface block and consumes its transfers.
//  Decodes word addresses into REG_NUM registers. Inserts a programmable number of wait states.
//  Flags PSLVERR on bad accesses. Serves as the bench's reference completer.
// PARAMETERS
//  ADDR_WIDTH   16            APB address width (bits)
//  DATA_WIDTH   32            APB data width (bits); multiple of 8
//  REG_NUM      16            number of word registers; index = paddr[..:log2(DATA_WIDTH/8)]
//  WAIT_CYCLES  0             wait states inserted per transfer (0..15)
//  ID_VALUE     32'hA0B0_0001 reset/constant value of read-only register REG_NUM-1
// PORTS
//  clk      in   1              clock, all state updates on posedge
//  rstn     in   1              asynchronous active-low reset
//  paddr    in   ADDR_WIDTH     byte address
//  psel     in   1              slave select
//  penable  in   1              access phase
//  pwrite   in   1              1=write, 0=read
//  pwdata   in   DATA_WIDTH     write data
//  pstrb    in   DATA_WIDTH/8   byte strobes (present only with APB_WSTRB_EN)
//  prdata   out  DATA_WIDTH     read data, valid when pready&&!pwrite
//  pready   out  1              transfer completion
//  pslverr  out  1              error response, valid only when pready=1
//  ctrl_o   out  DATA_WIDTH     live copy of register 0
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE; pready=0, pslverr=0, prdata=0; regs 0..REG_NUM-2 = 0; ctrl_o=0.
//  FSM states: IDLE, ACCESS, DONE.
//  - IDLE: psel&&!penable -> capture paddr/pwrite/pwdata(/pstrb); load wait counter = WAIT_CYCLES.
//    If WAIT_CYCLES=0, go to DONE with pready=1 registered; else go to ACCESS.
//  - ACCESS: counter decrements each cycle; at counter==1, go to DONE (pready=1 next cycle).
//  - DONE: pready=1 for exactly one cycle; write commits on this edge if psel&&penable&&!err.
//    Then IDLE, or directly capture again if a new setup phase is present.
//  Timing: 0-wait gives a standard 2-cycle APB transfer; N waits hold pready=0 for N access cycles.
//  prdata/pslverr registered together with pready; prdata=0 on writes and on errors.
//  err = addr low bits !=0 (misaligned) | index>=REG_NUM | write to REG_NUM-1 (read-only ID).
//    On err: no register change, pslverr=1.
//  Reads of REG_NUM-1 return ID_VALUE.
//  psel dropped before DONE: abort to IDLE, no write, pready stays 0.
//  penable=1 seen in IDLE without a prior setup cycle: ignored, no response.
//  Captured address/data are used; changes on bus during waits are ignored.
//  rstn asserted mid-transfer: immediate return to reset values; the transfer is lost.
// CONFIGURATION
//  APB_WSTRB_EN defined: pstrb port exists; write updates only bytes whose strobe=1.
//    pstrb=0 on a write is legal: no data change, pslverr=0.
//  APB_WSTRB_EN undefined: no pstrb port; every write updates the full word.
// TESTING
//  1 WAIT=0: write 0x1234_5678 to 0x0004, read 0x0004 -> pready 1 cycle after setup, prdata=0x1234_5678, pslverr=0.
//  2 WAIT=3: read 0x0000 after reset -> pready low 3 access cycles, then high 1 cycle, prdata=0.
//  3 Errors: read 0x0002 (misaligned) / 0x0040 (index 16) / write 0x003C (ID) -> pslverr=1.
//    A later read of 0x003C returns 0xA0B0_0001.
//  4 With APB_WSTRB_EN: reg0=0xFFFF_FFFF, write 0x0000_0000 with pstrb=4'b0101 -> ctrl_o=0xFF00_FF00.
//  5 WAIT=3: drop psel in 2nd wait cycle of write 0xDEAD_BEEF to 0x0008 -> no pready, later read 0x0008 = 0.
//  6 rstn low during a WAIT=3 write -> outputs and ctrl_o = 0 immediately; next read 0x0000 returns 0.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a master and apb_slave_regfile.
// Carries pstrb only when APB_WSTRB_EN is defined.
interface apb_slave_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] pstrb;
`endif
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

`ifdef APB_WSTRB_EN
    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
`else
    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
`endif
endinterface

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer holding REG_NUM word registers with a
// programmable number of wait states. The top register is a read-only ID.
// PSLVERR flags misaligned, out-of-range and ID-register writes.
// Optional feature macro: APB_WSTRB_EN enables per-byte write strobes (pstrb).
module apb_slave_regfile #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           REG_NUM     = 16,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 'hA0B0_0001
) (
    input  logic                  clk,
    input  logic                  rstn,
    apb_slave_regfile_if.slave    apb_io,
    output logic [DATA_WIDTH-1:0] ctrl_o
);
    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned IdxLsb   = $clog2(NumBytes);
    localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NumBytes-1:0]     wr_strb;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [DATA_WIDTH-1:0]   regs_q [REG_NUM-1];

    logic                    setup;
    logic                    capture;
    logic                    enter_done;
    logic                    commit;
    logic [ADDR_WIDTH-1:0]   src_addr;
    logic                    src_write;
    logic                    src_err;
    logic                    cap_err;
    int unsigned             src_idx;
    int unsigned             cap_idx;
    logic [DATA_WIDTH-1:0]   rd_val;

    function automatic logic is_err(logic [ADDR_WIDTH-1:0] addr, logic wr);
        int unsigned idx;
        idx = 32'(addr >> IdxLsb);
        return ((32'(addr) % NumBytes) != 0) || (idx >= REG_NUM) ||
               (wr && (idx == REG_NUM - 1));
    endfunction

    assign setup = apb_io.psel && !apb_io.penable;

    // Response is decided from the live bus when completing straight out of a
    // setup cycle (no wait states), otherwise from the captured transfer.
    assign src_addr  = (state_q == StAccess) ? addr_q  : apb_io.paddr;
    assign src_write = (state_q == StAccess) ? write_q : apb_io.pwrite;
    assign src_err   = is_err(src_addr, src_write);
    assign cap_err   = is_err(addr_q, write_q);
    assign src_idx   = 32'(src_addr >> IdxLsb);
    assign cap_idx   = 32'(addr_q >> IdxLsb);

`ifdef APB_WSTRB_EN
    logic [NumBytes-1:0] strb_q;
    assign wr_strb = strb_q;
`else
    assign wr_strb = '1;
`endif

    // Read mux; the ID register is a constant, not storage.
    always_comb begin
        rd_val = ID_VALUE;
        for (int unsigned i = 0; i < REG_NUM - 1; i++) begin
            if (src_idx == i) rd_val = regs_q[i];
        end
    end

    // Next-state, wait counter and transfer control strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        enter_done = 1'b0;
        commit     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StAccess;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StAccess: begin
                if (!apb_io.psel) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd1) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                commit  = apb_io.psel && apb_io.penable && write_q && !cap_err;
                state_d = StIdle;
                // Back-to-back setup may be captured without passing through idle.
                if (setup) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StAccess;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture of the setup-phase transfer; bus changes afterwards are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef APB_WSTRB_EN
            strb_q  <= '0;
`endif
        end else if (capture) begin
            addr_q  <= apb_io.paddr;
            write_q <= apb_io.pwrite;
            wdata_q <= apb_io.pwdata;
`ifdef APB_WSTRB_EN
            strb_q  <= apb_io.pstrb;
`endif
        end
    end

    // Registered response: pready, pslverr and prdata move together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= enter_done;
            pslverr_q <= enter_done && src_err;
            prdata_q  <= (enter_done && !src_write && !src_err) ? rd_val : '0;
        end
    end

    // Register storage; writes land on the completing edge, byte-masked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < REG_NUM - 1; i++) regs_q[i] <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < REG_NUM - 1; i++) begin
                if (cap_idx == i) begin
                    for (int unsigned b = 0; b < NumBytes; b++) begin
                        if (wr_strb[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign apb_io.pready  = pready_q;
    assign apb_io.pslverr = pslverr_q;
    assign apb_io.prdata  = prdata_q;
    assign ctrl_o         = regs_q[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 3 wait states) share one
// driven bus; expected responses are queued at setup and popped by a monitor.
module tb_apb_slave_regfile;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam logic [31:0] IdVal = 32'hA0B0_0001;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
`ifdef APB_WSTRB_EN
    logic [3:0]    pstrb;
`endif
    logic [DW-1:0] ctrl0, ctrl3;

    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    assign bus0.paddr = paddr;   assign bus3.paddr = paddr;
    assign bus0.psel = psel;     assign bus3.psel = psel;
    assign bus0.penable = penable; assign bus3.penable = penable;
    assign bus0.pwrite = pwrite; assign bus3.pwrite = pwrite;
    assign bus0.pwdata = pwdata; assign bus3.pwdata = pwdata;
`ifdef APB_WSTRB_EN
    assign bus0.pstrb = pstrb;   assign bus3.pstrb = pstrb;
`endif

    apb_slave_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(NR), .WAIT_CYCLES(0), .ID_VALUE(IdVal)
    ) dut0 (
        .clk(clk), .rstn(rstn), .apb_io(bus0.slave), .ctrl_o(ctrl0)
    );

    apb_slave_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUM(NR), .WAIT_CYCLES(3), .ID_VALUE(IdVal)
    ) dut3 (
        .clk(clk), .rstn(rstn), .apb_io(bus3.slave), .ctrl_o(ctrl3)
    );

    // Reference model: each instance is a plain array of words, top one is the ID.
    logic [31:0] mem0 [NR];
    logic [31:0] mem3 [NR];
    exp_t q0[$];
    exp_t q3[$];
    int n_cmp = 0;
    int n_fail = 0;
    int resp0 = 0;
    int resp3 = 0;
    exp_t e0, e3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mem0[i] = (i == NR - 1) ? IdVal : 32'h0;
            mem3[i] = (i == NR - 1) ? IdVal : 32'h0;
        end
    endtask

    // Apply one transfer to the model of one instance and queue its response.
    task automatic push_exp(input int which, input logic [15:0] a, input logic w,
                            input logic [31:0] d, input logic [3:0] s);
        int unsigned idx;
        logic err;
        exp_t e;
        idx = 32'(a) / 4;
        err = (a % 16'd4 != 16'd0) || (idx >= NR) || (w && idx == NR - 1);
        e.err = err;
        e.rdata = 32'h0;
        e.cyc = cyc + 1 + ((which == 0) ? 0 : 3);
        if (which == 0) begin
            if (!w && !err) e.rdata = mem0[idx];
            if (w && !err)
                for (int b = 0; b < 4; b++) if (s[b]) mem0[idx][8*b +: 8] = d[8*b +: 8];
            q0.push_back(e);
        end else begin
            if (!w && !err) e.rdata = mem3[idx];
            if (w && !err)
                for (int b = 0; b < 4; b++) if (s[b]) mem3[idx][8*b +: 8] = d[8*b +: 8];
            q3.push_back(e);
        end
    endtask

    task automatic drive_setup(input logic [15:0] a, input logic w, input logic [31:0] d,
                               input logic [3:0] s, output logic [3:0] eff);
        paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
`ifdef APB_WSTRB_EN
        pstrb = s;
        eff = s;
`else
        eff = 4'hF;
`endif
    endtask

    // Full transfer; call just after a rising edge. Bus is scrambled during waits.
    task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s);
        logic [3:0] eff;
        int t;
        drive_setup(a, w, d, s, eff);
        push_exp(0, a, w, d, eff);
        push_exp(3, a, w, d, eff);
        @(posedge clk); #1;
        penable = 1'b1;
        t = 0;
        while ((q0.size() != 0 || q3.size() != 0) && t < 20) begin
            @(posedge clk); #1;
            t++;
            paddr = 16'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
        end
        if (q0.size() != 0 || q3.size() != 0) begin
            check("response timeout", 32'(q0.size() + q3.size()), 32'd0);
            q0.delete(); q3.delete();
        end
        psel = 1'b0; penable = 1'b0;
        check("dut0 ctrl_o", ctrl0, mem0[0]);
        check("dut3 ctrl_o", ctrl3, mem3[0]);
    endtask

    // Monitor: every pready cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstn && bus0.pready) begin
            resp0++;
            if (q0.size() == 0) begin
                check("dut0 unexpected pready", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut0 prdata", bus0.prdata, e0.rdata);
                check("dut0 pslverr", 32'(bus0.pslverr), 32'(e0.err));
                check("dut0 latency", 32'(cyc), 32'(e0.cyc));
            end
        end
        if (rstn && bus3.pready) begin
            resp3++;
            if (q3.size() == 0) begin
                check("dut3 unexpected pready", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                check("dut3 prdata", bus3.prdata, e3.rdata);
                check("dut3 pslverr", 32'(bus3.pslverr), 32'(e3.err));
                check("dut3 latency", 32'(cyc), 32'(e3.cyc));
            end
        end
    end

    initial begin
        int r0, r3;
        logic [3:0] eff;
        logic [15:0] a;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
`ifdef APB_WSTRB_EN
        pstrb = 4'hF;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        check("reset dut0 pready", 32'(bus0.pready), 32'd0);
        check("reset dut0 pslverr", 32'(bus0.pslverr), 32'd0);
        check("reset dut0 prdata", bus0.prdata, 32'd0);
        check("reset dut0 ctrl_o", ctrl0, 32'd0);
        check("reset dut3 pready", 32'(bus3.pready), 32'd0);
        check("reset dut3 prdata", bus3.prdata, 32'd0);
        check("reset dut3 ctrl_o", ctrl3, 32'd0);

        // Basic write/readback, read of a reset register, error cases, ID read.
        xfer(16'h0004, 1'b1, 32'h1234_5678, 4'hF);
        xfer(16'h0004, 1'b0, 32'h0, 4'hF);
        xfer(16'h0000, 1'b0, 32'h0, 4'hF);
        xfer(16'h0002, 1'b0, 32'h0, 4'hF);
        xfer(16'h0040, 1'b0, 32'h0, 4'hF);
        xfer(16'h003C, 1'b1, 32'h5555_5555, 4'hF);
        xfer(16'h003C, 1'b0, 32'h0, 4'hF);

`ifdef APB_WSTRB_EN
        xfer(16'h0000, 1'b1, 32'hFFFF_FFFF, 4'hF);
        xfer(16'h0000, 1'b1, 32'h0000_0000, 4'b0101);
        check("strobe merge ctrl_o", ctrl0, 32'hFF00_FF00);
        xfer(16'h0000, 1'b1, 32'h1234_5678, 4'b0000);
        check("zero strobe ctrl_o", ctrl0, 32'hFF00_FF00);
`endif

        // Stray access phase with no setup must be ignored.
        r0 = resp0; r3 = resp3;
        psel = 1'b1; penable = 1'b1; paddr = 16'h0004; pwrite = 1'b0;
        repeat (6) @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("no-setup dut0 responses", 32'(resp0 - r0), 32'd0);
        check("no-setup dut3 responses", 32'(resp3 - r3), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k <= 6) a = 16'($urandom_range(0, NR - 1) * 4);
            else if (k == 7) a = 16'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
            else if (k == 8) a = 16'($urandom_range(NR, 40) * 4);
            else a = 16'((NR - 1) * 4);
            xfer(a, 1'($urandom), $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Abort: psel dropped in the second wait cycle of the 3-wait instance.
        @(posedge clk); #1;
        r3 = resp3;
        drive_setup(16'h0008, 1'b1, 32'hDEAD_BEEF, 4'hF, eff);
        push_exp(0, 16'h0008, 1'b1, 32'hDEAD_BEEF, eff);
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort dut3 responses", 32'(resp3 - r3), 32'd0);
        check("abort dut0 drained", 32'(q0.size()), 32'd0);
        xfer(16'h0008, 1'b0, 32'h0, 4'hF);

        // Reset mid-transfer: outputs clear at once, transfer is lost.
        @(posedge clk); #1;
        drive_setup(16'h0000, 1'b1, 32'h5555_AAAA, 4'hF, eff);
        push_exp(0, 16'h0000, 1'b1, 32'h5555_AAAA, eff);
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        check("pre-reset dut0 ctrl_o", ctrl0, mem0[0]);
        rstn = 1'b0;
        #1;
        check("mid-reset dut0 ctrl_o", ctrl0, 32'd0);
        check("mid-reset dut3 ctrl_o", ctrl3, 32'd0);
        check("mid-reset dut3 pready", 32'(bus3.pready), 32'd0);
        check("mid-reset dut3 prdata", bus3.prdata, 32'd0);
        check("mid-reset dut0 pslverr", 32'(bus0.pslverr), 32'd0);
        psel = 1'b0; penable = 1'b0;
        q0.delete(); q3.delete();
        model_reset();
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        xfer(16'h0000, 1'b0, 32'h0, 4'hF);
        xfer(16'h0010, 1'b1, 32'hCAFE_F00D, 4'hF);
        xfer(16'h0010, 1'b0, 32'h0, 4'hF);

        repeat (5) @(posedge clk);
        #1;
        check("leftover dut0 expectations", 32'(q0.size()), 32'd0);
        check("leftover dut3 expectations", 32'(q3.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
